hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the single-cycle load-use detector in the pipeline's decode stage. It tracks an outstanding-write countdown per architectural register, so producers with any result latency (load, multi-cycle multiply, memory with wait states) stall dependent consumers exactly as long as needed. It sits in ID and drives PC/IF-ID write enables and the ID/EX bubble. It also handles branch flush and keeps a saturating stall-cycle counter.

Parameters:
REG_AW, 4, register address width; NUM_REGS = 2**REG_AW
LAT_W, 3, width of the per-register latency countdown; max latency 2**LAT_W-1
ZERO_REG, 1, 1 = register 0 is hardwired zero and never tracked or stalled on
PERF_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a valid instruction
id_rs  input  REG_AW  source register 1 of the ID instruction
id_rt  input  REG_AW  source register 2 of the ID instruction
id_rs_used  input  1  ID instruction reads id_rs
id_rt_used  input  1  ID instruction reads id_rt
id_we  input  1  ID instruction writes a register
id_rd  input  REG_AW  destination register of the ID instruction
id_lat  input  LAT_W  cycles after issue before the result is forwardable; 0 = forwardable immediately, 1 = load
flush  input  1  branch/jump redirect: kill the ID instruction this cycle
stall  output  1  hazard detected, ID instruction held
pc_write  output  1  = ~stall
if_id_write  output  1  = ~stall
id_ex_bubble  output  1  insert NOP into ID/EX (stall | flush)
stall_cycles  output  PERF_W  saturating count of stall cycles

Behaviour:
- State: cnt[r], LAT_W bits, one per register. cnt[r]!=0 means r is not yet forwardable.
- Reset (async, rst_n=0): all cnt cleared; stall_cycles=0. Outputs while in reset: stall=0, pc_write=1, if_id_write=1, id_ex_bubble=0.
- stall is combinational, computed from the current registered cnt:
  - Condition: id_valid & ~flush & ((id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0)).
  - Sources equal to register 0 never hit when ZERO_REG=1.
- issue = id_valid & ~stall & ~flush. On issue with id_we=1, id_rd!=0 (or ZERO_REG=0), and id_lat!=0: cnt[id_rd] is loaded next edge.
- Each edge, every nonzero cnt not being loaded decrements by 1.
- Latency: a producer issued at cycle T with lat L stalls a dependent in ID for cycles T+1..T+L. The dependent issues at T+L+1. L=1 reproduces the classic one-bubble load-use stall.
- WAW: when loading cnt[id_rd] while it is nonzero, the loaded value is max(id_lat, cnt[id_rd]-1). A later write never shortens the pending window.
- Self-dependence: if the ID instruction reads and writes the same register, the stall check uses the old cnt only.
- flush: forces stall=0, no issue, no scoreboard load; id_ex_bubble=1. Countdowns already running continue; producers in flight still complete.
- id_valid=0: no stall, no issue; countdowns continue.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-countdown clears all pending state immediately; the first cycle after reset never stalls.

Decomposition:
- Shared pipeline package: register-address width, zero-register index, latency encodings (LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3).
- Natural sub-module: hazard_reg_counter, one per register. It holds a countdown with load/max-merge and a nonzero flag, instantiated NUM_REGS times via generate.

Test Plan:
- Load-use: issue load R3 with lat=1; next cycle ID reads R3 as rs -> stall=1, pc_write=0, id_ex_bubble=1 for exactly 1 cycle, then issue; stall_cycles=1.
- Multi-cycle: issue mul R5 with lat=3; consumer reads R5 as rt -> stall high 3 cycles, issues on 4th; an unrelated reader of R6 in between is not stalled.
- WAW merge: issue lat=3 to R2, then next cycle lat=1 to R2 -> cnt[R2]=2; reader stalls 2 cycles, not 1.
- Zero register: ZERO_REG=1, load R0 lat=1, then read R0 -> stall=0; rs_used=0 with rs=R3 pending -> stall=0.
- Flush during hazard: pending R4 with cnt=2, reader in ID with flush=1 -> stall=0, id_ex_bubble=1, no load; countdown reaches 0 two cycles later.
- Async reset with cnt[R7]=3 pending: assert rst_n=0 between edges -> stall drops immediately; after release, a read of R7 does not stall; stall_cycles=0. Separately, force 2**PERF_W stall cycles -> counter holds at all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the decode-stage hazard scoreboard.
// Default widths, the zero-register index and the standard producer latencies.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_AW_DEF   = 4;
    localparam int unsigned LAT_W_DEF    = 3;
    localparam int unsigned PERF_W_DEF   = 16;
    localparam int unsigned ZERO_REG_IDX = 0;

    // Cycles after issue before a producer's result can be forwarded.
    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 3;

    typedef struct packed {
        logic rs_hit;
        logic rt_hit;
    } hazard_hits_t;

    // A register is tracked unless it is the hardwired zero register.
    function automatic logic is_tracked(input int unsigned idx, input logic zero_reg);
        return !(zero_reg && (idx == ZERO_REG_IDX));
    endfunction

    function automatic int unsigned lat_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register outstanding-write countdown with max-merge on reload.
// o_busy is high while the register's pending result is not yet forwardable.
module hazard_reg_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_lat,
    output logic             o_busy
);

    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_dec;
    logic [LAT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_dec = (r_cnt != '0) ? (r_cnt - LAT_W'(1)) : '0;
        w_cnt_nxt = w_cnt_dec;
        // A later write never shortens a window that is still running.
        if (i_load) begin
            w_cnt_nxt = LAT_W'(lat_max(32'(i_lat), 32'(w_cnt_dec)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: stalls consumers of registers whose producers
// are still in flight, handles branch flush and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned LAT_W    = LAT_W_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned PERF_W   = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_rs_used,
    input  logic              i_id_rt_used,
    input  logic              i_id_we,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic [LAT_W-1:0]  i_id_lat,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_id_ex_bubble,
    output logic [PERF_W-1:0] o_stall_cycles
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_load;
    hazard_hits_t        w_hits;
    logic                w_stall;
    logic                w_issue;
    logic                w_wr_en;
    logic [PERF_W-1:0]   r_stall_cycles;

    // Hazard check sees only the registered counts, so self-dependence uses the old value.
    always_comb begin
        w_hits.rs_hit = i_id_rs_used && w_busy[i_id_rs] && is_tracked(32'(i_id_rs), ZERO_REG);
        w_hits.rt_hit = i_id_rt_used && w_busy[i_id_rt] && is_tracked(32'(i_id_rt), ZERO_REG);
        w_stall       = i_id_valid && !i_flush && (w_hits.rs_hit || w_hits.rt_hit);
        w_issue       = i_id_valid && !w_stall && !i_flush;
        w_wr_en       = w_issue && i_id_we && (i_id_lat != '0)
                        && is_tracked(32'(i_id_rd), ZERO_REG);
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_load[g] = w_wr_en && (i_id_rd == REG_AW'(g));

        hazard_reg_counter #(
            .LAT_W (LAT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load[g]),
            .i_lat  (i_id_lat),
            .o_busy (w_busy[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign o_stall        = w_stall;
    assign o_pc_write     = !w_stall;
    assign o_if_id_write  = !w_stall;
    assign o_id_ex_bubble = w_stall || i_flush;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, checked against a ready-time model of register availability.
module tb_hazard_scoreboard;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned LAT_W  = 3;
    localparam int unsigned PERF_W = 10;
    localparam int          NREGS  = 16;
    localparam int          PERF_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs = '0;
    logic [REG_AW-1:0] id_rt = '0;
    logic              id_rs_used = 1'b0;
    logic              id_rt_used = 1'b0;
    logic              id_we = 1'b0;
    logic [REG_AW-1:0] id_rd = '0;
    logic [LAT_W-1:0]  id_lat = '0;
    logic              flush = 1'b0;
    logic              stall;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic [PERF_W-1:0] stall_cycles;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .LAT_W    (LAT_W),
        .ZERO_REG (1'b1),
        .PERF_W   (PERF_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_valid     (id_valid),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_rs_used   (id_rs_used),
        .i_id_rt_used   (id_rt_used),
        .i_id_we        (id_we),
        .i_id_rd        (id_rd),
        .i_id_lat       (id_lat),
        .i_flush        (flush),
        .o_stall        (stall),
        .o_pc_write     (pc_write),
        .o_if_id_write  (if_id_write),
        .o_id_ex_bubble (id_ex_bubble),
        .o_stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each register becomes forwardable at an absolute cycle number.
    longint ready_m [NREGS];
    longint now_m = 0;
    int     perf_m = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int r, input bit used);
        return used && (r != 0) && (ready_m[r] > now_m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) ready_m[i] = 0;
        perf_m = 0;
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model over the next edge.
    task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                        input bit we, input int rd, input int lat, input bit fl,
                        output bit st);
        bit exp_st;
        id_valid   = v;
        id_rs      = REG_AW'(rs);
        id_rt      = REG_AW'(rt);
        id_rs_used = rsu;
        id_rt_used = rtu;
        id_we      = we;
        id_rd      = REG_AW'(rd);
        id_lat     = LAT_W'(lat);
        flush      = fl;
        #3;
        exp_st = v && !fl && (model_hit(rs, rsu) || model_hit(rt, rtu));
        chk("stall", stall, exp_st);
        chk("pc_write", pc_write, !exp_st);
        chk("if_id_write", if_id_write, !exp_st);
        chk("id_ex_bubble", id_ex_bubble, exp_st || fl);
        chk("stall_cycles", stall_cycles, perf_m);
        st = stall;
        @(posedge clk);
        if (exp_st && perf_m < PERF_MAX) perf_m++;
        if (v && !exp_st && !fl && we && lat != 0 && rd != 0) begin
            if (now_m + lat + 1 > ready_m[rd]) ready_m[rd] = now_m + lat + 1;
        end
        now_m++;
        #1;
    endtask

    task automatic issue(input int rd, input int lat);
        bit st;
        step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, rd, lat, 1'b0, st);
    endtask

    task automatic idle();
        bit st;
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, st);
    endtask

    // Holds a reader in ID until it issues; bounded so a stuck stall still terminates.
    task automatic reader(input int rs, input int rt, input bit rsu, input bit rtu,
                          output int n);
        bit st;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, rs, rt, rsu, rtu, 1'b0, 0, 0, 1'b0, st);
            if (!st) break;
            n++;
        end
    endtask

    task automatic do_reset();
        id_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        now_m++;
        #1;
    endtask

    initial begin
        int n;
        bit st;
        model_reset();

        // Outputs while held in reset.
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_write", if_id_write, 1);
        chk("rst_bubble", id_ex_bubble, 0);
        chk("rst_perf", stall_cycles, 0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        now_m++;
        #1;

        // Load-use: one bubble.
        issue(3, 1);
        reader(3, 0, 1'b1, 1'b0, n);
        chk("loaduse_stalls", n, 1);
        chk("loaduse_perf", stall_cycles, 1);

        // Multi-cycle producer read through rt.
        issue(5, 3);
        reader(0, 5, 1'b0, 1'b1, n);
        chk("mul_stalls", n, 3);
        issue(5, 3);
        reader(6, 0, 1'b1, 1'b0, n);
        chk("unrelated_stalls", n, 0);
        reader(0, 5, 1'b0, 1'b1, n);
        chk("mul_after_unrel", n, 2);

        // WAW: shorter later write keeps the longer window.
        issue(2, 3);
        issue(2, 1);
        reader(2, 2, 1'b1, 1'b1, n);
        chk("waw_stalls", n, 2);

        // Zero register and unused source.
        issue(0, 1);
        reader(0, 0, 1'b1, 1'b1, n);
        chk("zero_reg_stalls", n, 0);
        issue(3, 1);
        reader(3, 1, 1'b0, 1'b1, n);
        chk("unused_src_stalls", n, 0);

        // Flush over a pending hazard; the flushed write must not load.
        issue(4, 2);
        step(1'b1, 4, 0, 1'b1, 1'b0, 1'b1, 4, 7, 1'b1, st);
        chk("flush_stall", st, 0);
        reader(4, 0, 1'b1, 1'b0, n);
        chk("after_flush_stalls", n, 1);

        // Asynchronous reset in the middle of a countdown.
        issue(7, 3);
        id_valid   = 1'b1;
        id_rs      = REG_AW'(7);
        id_rs_used = 1'b1;
        id_rt_used = 1'b0;
        id_we      = 1'b0;
        flush      = 1'b0;
        #3;
        chk("pre_reset_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_pc_write", pc_write, 1);
        chk("midrst_bubble", id_ex_bubble, 0);
        chk("midrst_perf", stall_cycles, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        id_valid = 1'b0;
        @(posedge clk);
        now_m++;
        #1;
        reader(7, 0, 1'b1, 1'b0, n);
        chk("post_reset_stalls", n, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(7) != 0), $urandom_range(15), $urandom_range(15),
                 $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 $urandom_range(15), $urandom_range(7), ($urandom_range(7) == 0), st);
        end

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            issue(1, 7);
            reader(1, 0, 1'b1, 1'b0, n);
        end
        chk("perf_saturated", stall_cycles, PERF_MAX);
        issue(1, 7);
        reader(1, 0, 1'b1, 1'b0, n);
        chk("perf_held", stall_cycles, PERF_MAX);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
